// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the word-serial N x N multiplier.
package mult_pkg;

    localparam int W_DEFAULT = 32;
    localparam int K_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_nxn_fast_fsm.sv
// Control FSM: walks word pairs (i, j) with j innermost, bounded by na/nb.
module mult_nxn_fast_fsm
    import mult_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N),
    localparam int NW = cnt_w(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [NW-1:0] na,
    input  logic [NW-1:0] nb,
    output logic          busy,
    output logic          done,
    output logic          clr_prod,
    output logic          upd_prod,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j
);

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic          i_last;
    logic          j_last;

    assign i_last = (NW'(i_q) + NW'(1)) == na;
    assign j_last = (NW'(j_q) + NW'(1)) == nb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= MAC;
                        busy_q  <= 1'b1;
                        i_q     <= '0;
                        j_q     <= '0;
                    end
                end
                MAC: begin
                    if (j_last) begin
                        j_q <= '0;
                        if (i_last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            i_q     <= '0;
                        end else begin
                            i_q <= i_q + IW'(1);
                        end
                    end else begin
                        j_q <= j_q + IW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign clr_prod = (state_q == IDLE) && start;
    assign upd_prod = (state_q == MAC);
    assign i        = i_q;
    assign j        = j_q;

endmodule

// File: rtl/mult_nxn_fast.sv
// Word-serial unsigned multiplier: one K x K partial product per cycle,
// skipping word pairs above the highest nonzero word of either operand.
module mult_nxn_fast
    import mult_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int K = K_DEFAULT
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int N  = W / K;
    localparam int IW = idx_w(N);
    localparam int NW = cnt_w(N);

    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [NW-1:0]  na_q;
    logic [NW-1:0]  nb_q;
    logic [NW-1:0]  na_d;
    logic [NW-1:0]  nb_d;
    logic [2*W-1:0] prod_q;
    logic [2*W-1:0] prod_d;
    logic [K-1:0]   a_word;
    logic [K-1:0]   b_word;
    logic [2*K-1:0] pp;
    logic [2*W-1:0] term;
    logic           clr_prod;
    logic           upd_prod;
    logic [IW-1:0]  i;
    logic [IW-1:0]  j;

    mult_nxn_fast_fsm #(.N(N)) u_fsm (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .na       (na_q),
        .nb       (nb_q),
        .busy     (busy),
        .done     (done),
        .clr_prod (clr_prod),
        .upd_prod (upd_prod),
        .i        (i),
        .j        (j)
    );

    // Active word count = index of highest nonzero word + 1 (1 for zero).
    always_comb begin
        na_d = NW'(1);
        nb_d = NW'(1);
        for (int k = 0; k < N; k++) begin
            if (a[k*K +: K] != '0) na_d = NW'(k + 1);
            if (b[k*K +: K] != '0) nb_d = NW'(k + 1);
        end
    end

    always_comb begin
        a_word = a_q[K*int'(i) +: K];
        b_word = b_q[K*int'(j) +: K];
        pp     = (2*K)'(a_word) * (2*K)'(b_word);
        term   = (2*W)'(pp) << (K * (int'(i) + int'(j)));
        prod_d = prod_q;
        if (clr_prod) begin
            prod_d = '0;
        end else if (upd_prod) begin
            prod_d = prod_q + term;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            na_q   <= NW'(1);
            nb_q   <= NW'(1);
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
            if (clr_prod) begin
                a_q  <= a;
                b_q  <= b;
                na_q <= na_d;
                nb_q <= nb_d;
            end
        end
    end

    assign product = prod_q;

endmodule
